// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter in front of a single-port data memory
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          Resetn,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_done,
    output logic          m1_done,
    output logic          m0_err,
    output logic          m1_err,
    output logic [DW-1:0] rdata,
    output logic [31:0]   mem_RA,
    output logic [31:0]   mem_WA,
    output logic [DW-1:0] mem_Di,
    output logic          mem_MemWr,
    input  logic [DW-1:0] mem_Do,
    output logic [15:0]   conflicts
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [15:0]   conflicts_q, conflicts_d;

    logic in_range;
    logic serve;
    logic resp;
    logic both_req;
    logic winner;

    assign in_range = (addr_q[31:AW] == '0);
    assign serve    = (state_q == ST_SERVE);
    assign resp     = (state_q == ST_RESP);
    assign both_req = m0_req & m1_req;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        conflicts_d = conflicts_q;
        winner      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // With contention the master that did not win last time goes next.
                winner = both_req ? ~last_q : m1_req;
                if (m0_req || m1_req) begin
                    owner_d = winner;
                    last_d  = winner;
                    we_d    = winner ? m1_we    : m0_we;
                    addr_d  = winner ? m1_addr  : m0_addr;
                    wdata_d = winner ? m1_wdata : m0_wdata;
                    state_d = ST_SERVE;
                end
                if (both_req && (conflicts_q != 16'hFFFF)) begin
                    conflicts_d = conflicts_q + 16'd1;
                end
            end
            ST_SERVE: begin
                state_d = ST_RESP;
                if (!in_range) begin
                    rdata_d = '0;
                end else if (!we_q) begin
                    rdata_d = mem_Do;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            conflicts_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            conflicts_q <= conflicts_d;
        end
    end

    // Write enable is decoded from state so an async reset kills it before the memory's negedge.
    assign mem_MemWr = serve & we_q & in_range;
    assign mem_RA    = addr_q;
    assign mem_WA    = addr_q;
    assign mem_Di    = wdata_q;

    assign m0_gnt  = serve & ~owner_q;
    assign m1_gnt  = serve &  owner_q;
    assign m0_done = resp  & ~owner_q;
    assign m1_done = resp  &  owner_q;
    assign m0_err  = resp  & ~owner_q & ~in_range;
    assign m1_err  = resp  &  owner_q & ~in_range;

    assign rdata     = rdata_q;
    assign conflicts = conflicts_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning word-address width of the data memory (256 words).
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_req / m1_req  input  1  transaction request from master 0 / 1.
REQ-006 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr / m1_addr  input  32  word address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  DW  write data.
REQ-009 SHALL have ports m0_gnt / m1_gnt  output  1  one-cycle pulse: request accepted and executing.
REQ-010 SHALL have ports m0_done / m1_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports m0_err / m1_err  output  1  one-cycle pulse with done when the address is out of range.
REQ-012 SHALL have port rdata  output  DW  registered read data, valid while a done is high for a read.
REQ-013 SHALL have ports mem_RA / mem_WA  output  32  memory read / write address.
REQ-014 SHALL have ports mem_Di  output  DW  and mem_MemWr  output  1  memory write data / write enable.
REQ-015 SHALL have port mem_Do  input  DW  asynchronous memory read data.
REQ-016 SHALL have port conflicts  output  16  saturating count of contended arbitration cycles.

Function
REQ-017 SHALL implement FSM IDLE -> SERVE -> RESP -> IDLE, one transaction per pass, 3 cycles minimum per transaction.
REQ-018 In IDLE with any request, SHALL pick a winner, latch its we/addr/wdata and master id at the posedge, and enter SERVE.
REQ-019 SHALL arbitrate round-robin: with both requests, grant the master not granted last; with one request, grant it regardless of pointer.
REQ-020 SHALL update the last-granted pointer on every IDLE->SERVE transition.
REQ-021 SHALL assert gnt of the latched master only during SERVE; the master may drop req and change fields after seeing gnt.
REQ-022 During SERVE, SHALL drive mem_RA and mem_WA with the latched address, mem_Di with the latched wdata, and mem_MemWr = latched we AND address in range, so the memory's negedge write completes inside SERVE.
REQ-023 Out of range SHALL mean addr[31:AW] != 0: no write occurs (mem_MemWr 0), rdata is loaded with 0, and err pulses with done.
REQ-024 At the SERVE->RESP edge, SHALL load rdata with mem_Do for in-range reads; writes leave rdata unchanged.
REQ-025 SHALL assert done of the latched master for exactly the RESP cycle.
REQ-026 A req still high during RESP SHALL be a new request, arbitrated in the next IDLE; requests seen in SERVE or RESP are not accepted.
REQ-027 In IDLE, SHALL increment conflicts when m0_req and m1_req are both 1, and hold it at 16'hFFFF.
REQ-028 Outside SERVE, mem_MemWr SHALL be 0 and mem_RA, mem_WA and mem_Di SHALL hold the last latched values.

Reset
REQ-029 Resetn low SHALL immediately set state IDLE, all gnt/done/err 0, mem_MemWr 0, rdata 0, mem_RA/mem_WA/mem_Di 0, conflicts 0, and the pointer to "master 1 last", so master 0 wins the first contention.
REQ-030 Resetn asserted mid-SERVE SHALL abort the transaction: no done, and no write if asserted before the CLK negedge.
REQ-031 Release of Resetn SHALL take effect at the first posedge with Resetn high; IDLE is sampled on that edge.

Verification
REQ-032 After reset, m0 writes addr 5 with 0xDEADBEEF -> m0_gnt in cycle 1, mem_MemWr 1 in cycle 1 only, m0_done in cycle 2; a later m0 read of addr 5 gives rdata 0xDEADBEEF with done.
REQ-033 m0 and m1 both request reads (addr 3, addr 7) in the same cycle -> m0 is served first (rdata 3), then m1 (rdata 7, memory preloaded mem[i]=i); conflicts = 1.
REQ-034 Both masters hold req continuously for 6 transactions -> grants alternate m0,m1,m0,m1,m0,m1; conflicts increments once per arbitration.
REQ-035 m1 writes addr 0x100 -> m1_done and m1_err pulse together, mem_MemWr stays 0, and memory is unchanged.
REQ-036 Resetn pulsed low during SERVE of a write to addr 2, before the negedge -> mem[2] is unchanged, no done pulse, all outputs 0, and the next contention grants m0.
